serial_seq_tx: RTL and testbench

Serialiser that generates the single-bit `x` stream consumed by the team's Moore sequence-detector FSMs. Software or bench logic hands it a parallel word and a bit count over a valid/ready handshake. The block shifts the word out MSB-first, one bit per clock, then inserts an idle gap before accepting the next word. It sits directly upstream of a detector's `x` input.

---
 rtl/serial_seq_tx.sv | 153 +++++++++++++++
 tb/tb_serial_seq_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_tx.sv
// serial_seq_tx: parallel-to-serial source for the Moore sequence detectors.
// Takes a word plus bit count over valid/ready, shifts it out MSB-first
// one bit per clock on x/x_valid, pulses done, then idles for a fixed gap.
module serial_seq_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  localparam int LW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // A length of zero, or one larger than the word, means "send the full word".
  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
    if ((len == LW'(0)) || (len > LW'(WIDTH))) begin
      return LW'(WIDTH);
    end else begin
      return len;
    end
  endfunction

  state_t           state_r,    state_s;
  logic [WIDTH-1:0] sr_r,       sr_s;
  logic [LW-1:0]    cnt_r,      cnt_s;
  logic [3:0]       gcnt_r,     gcnt_s;
  logic             x_r,        x_s;
  logic             x_valid_r,  x_valid_s;
  logic             done_r,     done_s;
  logic             in_ready_r, in_ready_s;
  logic             busy_r,     busy_s;

  logic [LW-1:0]    len_eff_s;
  logic [LW-1:0]    shamt_s;
  logic [WIDTH-1:0] aligned_s;

  // Left-align the offered word so its first payload bit sits at the MSB.
  always_comb begin
    len_eff_s = eff_len(in_len);
    shamt_s   = LW'(WIDTH) - len_eff_s;
    aligned_s = in_data << shamt_s;
  end

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s    = state_r;
    sr_s       = sr_r;
    cnt_s      = cnt_r;
    gcnt_s     = gcnt_r;
    x_s        = 1'b0;
    x_valid_s  = 1'b0;
    done_s     = 1'b0;
    in_ready_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // in_ready_r is low for the done cycle when there is no gap, so a
        // word can never be accepted in the same cycle done is shown.
        if (in_valid && in_ready_r) begin
          state_s   = ST_SHIFT;
          sr_s      = aligned_s;
          cnt_s     = len_eff_s;
          x_s       = aligned_s[WIDTH-1];
          x_valid_s = 1'b1;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        // cnt_r counts bits still on the wire including the one now shown.
        if (cnt_r <= LW'(1)) begin
          done_s = 1'b1;
          sr_s   = '0;
          cnt_s  = '0;
          if (GAP_CYCLES > 0) begin
            state_s = ST_GAP;
            gcnt_s  = 4'(GAP_CYCLES);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          sr_s      = {sr_r[WIDTH-2:0], 1'b0};
          cnt_s     = cnt_r - LW'(1);
          x_s       = sr_r[WIDTH-2];
          x_valid_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_r <= 4'd1) begin
          state_s    = ST_IDLE;
          gcnt_s     = 4'd0;
          in_ready_s = 1'b1;
        end else begin
          gcnt_s = gcnt_r - 4'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        sr_s       = '0;
        cnt_s      = '0;
        gcnt_s     = 4'd0;
        in_ready_s = 1'b1;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      sr_r       <= '0;
      cnt_r      <= '0;
      gcnt_r     <= 4'd0;
      x_r        <= 1'b0;
      x_valid_r  <= 1'b0;
      done_r     <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sr_r       <= sr_s;
      cnt_r      <= cnt_s;
      gcnt_r     <= gcnt_s;
      x_r        <= x_s;
      x_valid_r  <= x_valid_s;
      done_r     <= done_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
    end
  end

  assign x        = x_r;
  assign x_valid  = x_valid_r;
  assign done     = done_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_serial_seq_tx.sv
// tb_serial_seq_tx: directed, table-driven bench for serial_seq_tx
// (WIDTH=8, GAP_CYCLES=2) with a behavioural 1011 Moore detector downstream.
module tb_serial_seq_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_seq_tx #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .x        (x),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Overlapping 1011 Moore detector fed straight from x every cycle.
  logic [2:0] det_st;
  logic       det_en = 1'b0;
  int         z_cnt  = 0;

  // Detector state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_st <= 3'd0;
    end else begin
      case (det_st)
        3'd0:    det_st <= x ? 3'd1 : 3'd0;
        3'd1:    det_st <= x ? 3'd1 : 3'd2;
        3'd2:    det_st <= x ? 3'd3 : 3'd0;
        3'd3:    det_st <= x ? 3'd4 : 3'd2;
        3'd4:    det_st <= x ? 3'd1 : 3'd2;
        default: det_st <= 3'd0;
      endcase
    end
  end

  // Count cycles in which the detector's z output (state 1011) is high.
  always @(negedge clk) begin
    if (det_en && (det_st == 3'd4)) z_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs packed as {x_valid, x, done, in_ready, busy}
  function automatic logic [31:0] outs();
    return 32'({x_valid, x, done, in_ready, busy});
  endfunction

  // Hand over one word and check every cycle until the block is idle again.
  task automatic send_word(input logic [7:0] data, input logic [3:0] len,
                           input logic [7:0] exp_bits, input int exp_n, input string name);
    @(negedge clk);
    check({name, "_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_len   = len;
    for (int j = 0; j < exp_n; j++) begin
      @(negedge clk);
      if (j == 0) begin
        in_valid = 1'b0;
        in_data  = ~data;
        in_len   = 4'd3;
      end
      check($sformatf("%s_bit%0d", name, j), outs(),
            32'({1'b1, exp_bits[exp_n-1-j], 1'b0, 1'b0, 1'b1}));
    end
    @(negedge clk);
    check({name, "_done"}, outs(), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
    for (int g = 1; g < GAP; g++) begin
      @(negedge clk);
      check($sformatf("%s_gap%0d", name, g), outs(), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    end
    @(negedge clk);
    check({name, "_idle_after"}, outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [7:0] exp_bits;
    int         exp_n;
    string      name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          dcount;
    logic [15:0] ev;
    logic [15:0] ex;

    vecs[0] = '{8'h0B, 4'd4,  8'h0B, 4, "single_0B_len4"};
    vecs[1] = '{8'h81, 4'd0,  8'h81, 8, "clamp_len0"};
    vecs[2] = '{8'h81, 4'd9,  8'h81, 8, "clamp_len9"};
    vecs[3] = '{8'hFE, 4'd1,  8'h00, 1, "len1_FE"};
    vecs[4] = '{8'h3C, 4'd15, 8'h3C, 8, "clamp_len15"};
    vecs[5] = '{8'h5A, 4'd8,  8'h5A, 8, "full_5A"};
    vecs[6] = '{8'h06, 4'd3,  8'h06, 3, "len3_06"};
    vecs[7] = '{8'hF2, 4'd2,  8'h02, 2, "len2_F2"};

    // Reset held with a word offered: nothing may be accepted.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_len   = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("reset_release_idle", outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));

    // Table of single words.
    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].data, vecs[v].len, vecs[v].exp_bits, vecs[v].exp_n, vecs[v].name);
    end

    // Back-to-back with in_valid held: A5 (8 bits) then 03 (2 bits).
    ev = 16'b1111_1111_0001_1000;
    ex = 16'b1010_0101_0001_1000;
    dcount = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_len   = 4'd8;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_data = 8'h03;
        in_len  = 4'd2;
      end
      if (i == 11) in_valid = 1'b0;
      check($sformatf("b2b_xv%0d", i), 32'({x_valid, x}), 32'({ev[15-i], ex[15-i]}));
      if (done) dcount++;
      if (i == 8)  check("b2b_ready_at_done", 32'(in_ready), 32'd0);
      if (i == 10) check("b2b_ready_reopen", 32'(in_ready), 32'd1);
    end
    check("b2b_done_pulses", 32'(dcount), 32'd2);
    check("b2b_idle_end", 32'(in_ready), 32'd1);

    // Abort: reset after the third bit of FF.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_len   = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("abort_bit%0d", i), 32'({x_valid, x}), 32'({1'b1, 1'b1}));
    end
    #2 reset = 1'b0;
    #1 check("abort_async_clear", outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_after%0d", i), outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    end
    send_word(8'h0B, 4'd4, 8'h0B, 4, "post_abort_0B");

    // End-to-end into the 1011 detector: one hit per word.
    det_en = 1'b1;
    send_word(8'h0B, 4'd4, 8'h0B, 4, "det_1011");
    send_word(8'h6B, 4'd7, 8'h6B, 7, "det_1101011");
    @(negedge clk);
    det_en = 1'b0;
    check("det_z_count", 32'(z_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
